// File: rtl/branch_operand_hazard_unit.sv
// ID-stage forwarding select and stall sequencer for branches/jr resolved in ID.
// Optional stall-cycle counter enabled by defining BRANCH_HAZARD_PERF_EN.
module branch_operand_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic                          id_is_branch,
    input  logic                          id_flush,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          ex_regwrite,
    input  logic                          ex_memread,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          mem_regwrite,
    input  logic                          mem_memread,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          wb_regwrite,
    input  logic [REG_ADDR_W-1:0]         wb_rd,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          pc_write,
    output logic                          ifid_write,
    output logic                          ctrl_bubble,
    output logic [CNT_W-1:0]              stall_cycles
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t               state, state_next;
    logic [1:0]           remain, remain_next;
    logic [1:0]           need_src [NUM_SRC];
    logic [1:0]           need;
    logic [2*NUM_SRC-1:0] fwd_raw;
    logic                 stall_raw;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [REG_ADDR_W-1:0] addr;
        logic                  active, ex_hit, mem_hit, wb_hit;

        assign addr    = id_src_addr[g*REG_ADDR_W +: REG_ADDR_W];
        assign active  = id_valid & id_is_branch & id_src_used[g] & (addr != '0);
        assign ex_hit  = ex_regwrite & (ex_rd == addr);
        assign mem_hit = mem_regwrite & (mem_rd == addr);
        assign wb_hit  = wb_regwrite & (wb_rd == addr);

        assign need_src[g] = !active                 ? 2'd0 :
                             ex_hit                  ? (ex_memread ? 2'd2 : 2'd1) :
                             (mem_hit & mem_memread) ? 2'd1 : 2'd0;

        // EX/MEM ALU result wins over MEM/WB; a load in MEM is never forwarded from there
        assign fwd_raw[2*g +: 2] = !active                  ? 2'b00 :
                                   (mem_hit & !mem_memread) ? 2'b01 :
                                   wb_hit                   ? 2'b10 : 2'b00;
    end

    always_comb begin
        need = 2'd0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (need_src[i] > need) need = need_src[i];
        end
    end

    always_comb begin
        stall_raw   = 1'b0;
        state_next  = state;
        remain_next = remain;
        case (state)
            IDLE: begin
                if ((need != 2'd0) && !id_flush) begin
                    stall_raw = 1'b1;
                    if (need == 2'd2) begin
                        state_next  = STALL;
                        remain_next = 2'd1;
                    end
                end
            end
            STALL: begin
                if (id_flush) begin
                    state_next  = IDLE;
                    remain_next = 2'd0;
                end else begin
                    stall_raw   = 1'b1;
                    remain_next = (remain != 2'd0) ? remain - 2'd1 : 2'd0;
                    if (remain <= 2'd1) state_next = IDLE;
                end
            end
            default: begin
                state_next  = IDLE;
                remain_next = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            remain <= 2'd0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
        end
    end

    assign stall       = stall_raw & !reset;
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign ctrl_bubble = stall;
    assign fwd_sel     = reset ? '0 : fwd_raw;

`ifdef BRANCH_HAZARD_PERF_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (stall && (cnt != '1))
            cnt <= cnt + CNT_W'(1);
    end

    assign stall_cycles = cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_branch_operand_hazard_unit.sv
// Self-checking bench for branch_operand_hazard_unit: directed scenarios plus random traffic
// compared against a behavioural model of the stall/forwarding rules.
module tb_branch_operand_hazard_unit;

    localparam int AW   = 5;
    localparam int NSRC = 2;
    localparam int CW   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            id_valid, id_is_branch, id_flush;
    logic [NSRC*AW-1:0] id_src_addr;
    logic [NSRC-1:0] id_src_used;
    logic            ex_regwrite, ex_memread;
    logic [AW-1:0]   ex_rd;
    logic            mem_regwrite, mem_memread;
    logic [AW-1:0]   mem_rd;
    logic            wb_regwrite;
    logic [AW-1:0]   wb_rd;
    logic [2*NSRC-1:0] fwd_sel;
    logic            stall, pc_write, ifid_write, ctrl_bubble;
    logic [CW-1:0]   stall_cycles;

    int total = 0;
    int bad   = 0;

    // model state: forced stall cycles still owed, and the perf counter
    int pending = 0;
    int m_cnt   = 0;
    logic exp_stall;
    logic [2*NSRC-1:0] exp_fwd;

    branch_operand_hazard_unit #(.REG_ADDR_W(AW), .NUM_SRC(NSRC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_flush(id_flush), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_rd(mem_rd),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .fwd_sel(fwd_sel), .stall(stall),
        .pc_write(pc_write), .ifid_write(ifid_write), .ctrl_bubble(ctrl_bubble),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Evaluate the rules for the currently driven inputs
    task automatic model_eval(output int need, output logic [2*NSRC-1:0] fwd);
        need = 0;
        fwd  = '0;
        for (int i = 0; i < NSRC; i++) begin
            logic [AW-1:0] a;
            int n;
            a = id_src_addr[i*AW +: AW];
            if (id_valid && id_is_branch && id_src_used[i] && a != 0) begin
                n = 0;
                if (ex_regwrite && ex_rd == a) n = max2(n, ex_memread ? 2 : 1);
                if (mem_regwrite && mem_memread && mem_rd == a) n = max2(n, 1);
                need = max2(need, n);
                if (mem_regwrite && !mem_memread && mem_rd == a) fwd[2*i +: 2] = 2'b01;
                else if (wb_regwrite && wb_rd == a)             fwd[2*i +: 2] = 2'b10;
            end
        end
    endtask

    // Inputs are already driven (just after a rising edge); check, clock, update model
    task automatic cycle(input string tag);
        int need;
        #1;
        model_eval(need, exp_fwd);
        if (reset)             exp_stall = 1'b0;
        else if (pending > 0)  exp_stall = !id_flush;
        else                   exp_stall = (need != 0) && !id_flush;
        if (reset) exp_fwd = '0;
        chk({tag, "_stall"},  32'(stall), 32'(exp_stall));
        chk({tag, "_pcw"},    32'(pc_write), 32'(!exp_stall));
        chk({tag, "_ifidw"},  32'(ifid_write), 32'(!exp_stall));
        chk({tag, "_bubble"}, 32'(ctrl_bubble), 32'(exp_stall));
        chk({tag, "_fwd"},    32'(fwd_sel), 32'(exp_fwd));
        @(posedge clk);
        if (reset)             pending = 0;
        else if (pending > 0)  pending = id_flush ? 0 : pending - 1;
        else if (need == 2 && !id_flush) pending = 1;
`ifdef BRANCH_HAZARD_PERF_EN
        if (reset) m_cnt = 0;
        else if (exp_stall && m_cnt < (1 << CW) - 1) m_cnt++;
`else
        m_cnt = 0;
`endif
        #1;
        chk({tag, "_cnt"}, 32'(stall_cycles), 32'(m_cnt));
    endtask

    task automatic clear_inputs();
        reset = 0; id_valid = 0; id_is_branch = 0; id_flush = 0;
        id_src_addr = '0; id_src_used = '0;
        ex_regwrite = 0; ex_memread = 0; ex_rd = '0;
        mem_regwrite = 0; mem_memread = 0; mem_rd = '0;
        wb_regwrite = 0; wb_rd = '0;
    endtask

    task automatic branch(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [1:0] used);
        id_valid = 1; id_is_branch = 1; id_src_used = used;
        id_src_addr = {rt, rs};
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        reset = 1;
        cycle(tag);
        reset = 0;
    endtask

    initial begin
        clear_inputs();
        @(posedge clk); #1;

        // Reset with a live load-use hazard: outputs forced inactive
        reset = 1; branch(5'd3, 5'd4, 2'b11);
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd3;
        wb_regwrite = 1; wb_rd = 5'd4;
        cycle("rst0");
        chk("rst0_fwd_zero", 32'(fwd_sel), 32'd0);
        cycle("rst1");
        reset = 0;

        // Test 1: lw $3 in EX, beq $3,$4 -> two stall cycles then MEM/WB forward
        clear_inputs(); branch(5'd3, 5'd4, 2'b11);
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd3;
        cycle("t1a");
        chk("t1a_stall_const", 32'(stall), 32'd1);
        ex_regwrite = 0; ex_memread = 0; ex_rd = '0;
        mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd3;
        cycle("t1b");
        chk("t1b_pcw_const", 32'(pc_write), 32'd0);
        mem_regwrite = 0; mem_memread = 0; mem_rd = '0;
        wb_regwrite = 1; wb_rd = 5'd3;
        cycle("t1c");
        chk("t1c_fwd_const", 32'(fwd_sel[1:0]), 32'h2);
        chk("t1c_stall_const", 32'(stall), 32'd0);

        // Test 2: add $5 in EX, jr $5 -> one stall then EX/MEM forward
        clear_inputs(); branch(5'd5, 5'd0, 2'b01);
        ex_regwrite = 1; ex_rd = 5'd5;
        cycle("t2a");
        ex_regwrite = 0; ex_rd = '0;
        mem_regwrite = 1; mem_rd = 5'd5;
        cycle("t2b");
        chk("t2b_fwd_const", 32'(fwd_sel[1:0]), 32'h1);

        // Test 3: independent per-source forwarding, then MEM priority
        clear_inputs(); branch(5'd6, 5'd7, 2'b11);
        mem_regwrite = 1; mem_rd = 5'd6; wb_regwrite = 1; wb_rd = 5'd7;
        cycle("t3a");
        chk("t3a_fwd_const", 32'(fwd_sel), 32'h9);
        wb_rd = 5'd6;
        cycle("t3b");
        chk("t3b_fwd_const", 32'(fwd_sel), 32'h1);

        // Test 4: register zero never forwards or stalls
        clear_inputs(); branch(5'd0, 5'd0, 2'b11);
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd0;
        mem_regwrite = 1; mem_rd = 5'd0; wb_regwrite = 1; wb_rd = 5'd0;
        cycle("t4");

        // Flush alongside a load-use hazard in IDLE: no stall, no STALL entry
        clear_inputs(); branch(5'd9, 5'd0, 2'b01);
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd9; id_flush = 1;
        cycle("fl_idle");
        clear_inputs();
        cycle("fl_idle_after");

        // Test 5a: flush in STALL drops the stall that cycle and returns to IDLE
        clear_inputs(); branch(5'd3, 5'd4, 2'b11);
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd3;
        cycle("t5a_enter");
        clear_inputs(); id_flush = 1;
        mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd3;
        cycle("t5a_flush");
        chk("t5a_flush_const", 32'(stall), 32'd0);
        clear_inputs();
        cycle("t5a_idle");

        // Test 5b: reset in STALL
        clear_inputs(); branch(5'd3, 5'd4, 2'b11);
        ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd3;
        cycle("t5b_enter");
        reset = 1;
        cycle("t5b_reset");
        chk("t5b_cnt_const", 32'(stall_cycles), 32'd0);
        clear_inputs();
        cycle("t5b_idle");

        // Test 6: five back-to-back stall cycles exercise counter saturation
        do_reset("t6_rst");
        branch(5'd8, 5'd0, 2'b01); ex_regwrite = 1; ex_rd = 5'd8;
        for (int i = 0; i < 5; i++) cycle("t6");

        // Random traffic over a small register set to provoke matches
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 39) == 0);
            id_valid     = ($urandom_range(0, 5) != 0);
            id_is_branch = ($urandom_range(0, 4) != 0);
            id_flush     = ($urandom_range(0, 7) == 0);
            id_src_used  = 2'($urandom);
            id_src_addr  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            ex_regwrite  = 1'($urandom); ex_memread  = 1'($urandom); ex_rd  = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom); mem_memread = 1'($urandom); mem_rd = 5'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom); wb_rd = 5'($urandom_range(0, 3));
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
